// File: rtl/bus_xfer_seq.sv
// Single-master bus transfer sequencer: one command at a time, rate-limited req,
// address/data phase with wait states, completion status with priority and timeout.
module bus_xfer_seq #(
  parameter int WINDOW   = 10,
  parameter int MAX_REQ  = 2,
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        req,
  input  logic        gnt,
  input  logic        strb,
  input  logic        fail_n,
  input  logic        abort_n,
  output logic [1:0]  st,
  output logic        be_n,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        start,
  output logic        end_,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status
);

  localparam int HW = WINDOW - 1;
  localparam int CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
  localparam logic [CW-1:0] WCNT_LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ARB  = 2'b01,
    S_XFER = 2'b10,
    S_WAIT = 2'b11
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  localparam logic [1:0] RS_OK    = 2'b00;
  localparam logic [1:0] RS_FAIL  = 2'b01;
  localparam logic [1:0] RS_ABORT = 2'b10;
  localparam logic [1:0] RS_TMO   = 2'b11;

  state_t        state;
  cmd_t          cmd_q;
  logic [CW-1:0] wcnt;
  logic [HW-1:0] hist, hist_nxt;
  int            req_cnt;
  logic          term;
  logic [1:0]    term_status;

  // History holds req of the last WINDOW-1 cycles; a new command may only
  // start when that leaves room for one more pulse in any WINDOW span.
  always_comb begin
    hist_nxt    = hist << 1;
    hist_nxt[0] = req;
    req_cnt     = 0;
    for (int i = 0; i < HW; i++) req_cnt += int'(hist[i]);
  end

  assign cmd_ready = rst_n && (state == S_IDLE) && (req_cnt < MAX_REQ);
  assign st        = state;

  always_comb begin
    term        = 1'b1;
    term_status = RS_OK;
    if (!abort_n)               term_status = RS_ABORT;
    else if (!fail_n)           term_status = RS_FAIL;
    else if (strb)              term_status = RS_OK;
    else if (wcnt == WCNT_LAST) term_status = RS_TMO;
    else                        term        = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cmd_q      <= '0;
      wcnt       <= '0;
      hist       <= '0;
      req        <= 1'b0;
      be_n       <= 1'b1;
      addr       <= '0;
      data       <= '0;
      start      <= 1'b0;
      end_       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= RS_OK;
    end else begin
      hist      <= hist_nxt;
      req       <= 1'b0;
      start     <= 1'b0;
      end_      <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q.addr <= cmd_addr;
            cmd_q.data <= cmd_write ? cmd_data : 32'h0;
            req        <= 1'b1;
            state      <= S_ARB;
          end
        end
        S_ARB: begin
          if (!abort_n) begin
            state      <= S_IDLE;
            rsp_valid  <= 1'b1;
            rsp_status <= RS_ABORT;
          end else if (gnt) begin
            state <= S_XFER;
            start <= 1'b1;
            be_n  <= 1'b0;
            addr  <= cmd_q.addr;
            data  <= cmd_q.data;
            wcnt  <= '0;
          end
        end
        S_XFER, S_WAIT: begin
          if (term) begin
            state      <= S_IDLE;
            be_n       <= 1'b1;
            end_       <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_status <= term_status;
          end else begin
            state <= S_WAIT;
            wcnt  <= wcnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: cycle-level reference model compared every
// cycle, plus hand-computed literal expectations for the key scenarios.
module tb_bus_xfer_seq;
  localparam int WINDOW   = 10;
  localparam int MAX_REQ  = 2;
  localparam int WAIT_MAX = 16;

  logic clk = 0, rst_n = 1;
  logic cmd_valid = 0, cmd_write = 0, gnt = 0, strb = 0, fail_n = 1, abort_n = 1;
  logic [31:0] cmd_addr = 0, cmd_data = 0;
  logic cmd_ready, req, be_n, start, end_, rsp_valid;
  logic [1:0] st, rsp_status;
  logic [31:0] addr, data;

  int n_checks = 0, n_fail = 0;

  bus_xfer_seq #(.WINDOW(WINDOW), .MAX_REQ(MAX_REQ), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .req(req), .gnt(gnt), .strb(strb), .fail_n(fail_n), .abort_n(abort_n),
    .st(st), .be_n(be_n), .addr(addr), .data(data), .start(start), .end_(end_),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 arbitrating, 2 first bus cycle, 3 waiting.
  int          m_ph = 0, age = 0, cyc = 0;
  logic        e_req = 0, e_be_n = 1, e_start = 0, e_end = 0, e_rv = 0, e_ready = 0;
  logic [1:0]  e_rs = 0;
  logic [31:0] e_addr = 0, e_data = 0, p_addr = 0, p_data = 0;
  int          req_times[$];

  task automatic m_reset();
    m_ph = 0; age = 0; e_req = 0; e_be_n = 1; e_start = 0; e_end = 0; e_rv = 0;
    e_rs = 0; e_addr = 0; e_data = 0; p_addr = 0; p_data = 0;
    req_times.delete();
  endtask

  function automatic int recent_reqs();
    int n = 0;
    foreach (req_times[k]) if (req_times[k] >= cyc - (WINDOW - 1)) n++;
    return n;
  endfunction

  task automatic m_step();
    logic done;
    logic [1:0] rs;
    e_req = 0; e_start = 0; e_end = 0; e_rv = 0;
    case (m_ph)
      0: if (cmd_valid && e_ready) begin
           p_addr = cmd_addr; p_data = cmd_write ? cmd_data : 32'h0;
           e_req = 1; m_ph = 1;
         end
      1: if (!abort_n) begin
           m_ph = 0; e_rv = 1; e_rs = 2'd2;
         end else if (gnt) begin
           m_ph = 2; e_start = 1; e_be_n = 0; e_addr = p_addr; e_data = p_data; age = 1;
         end
      default: begin
        done = 1; rs = 0;
        if (!abort_n) rs = 2'd2;
        else if (!fail_n) rs = 2'd1;
        else if (strb) rs = 2'd0;
        else if (age == WAIT_MAX) rs = 2'd3;
        else done = 0;
        if (done) begin
          m_ph = 0; e_be_n = 1; e_end = 1; e_rv = 1; e_rs = rs;
        end else begin
          m_ph = 3; age++;
        end
      end
    endcase
  endtask

  initial begin
    logic [73:0] act_v, exp_v;
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      e_ready = rst_n && (m_ph == 0) && (recent_reqs() < MAX_REQ);
      exp_v = {2'(m_ph), e_req, e_be_n, e_addr, e_data, e_start, e_end, e_rv, e_rs, e_ready};
      act_v = {st, req, be_n, addr, data, start, end_, rsp_valid, rsp_status, cmd_ready};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle%0d outputs act=%h exp=%h", cyc, act_v, exp_v);
      end
      if (e_req) req_times.push_back(cyc);
      if (rst_n) m_step();
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Offers a command, waits (bounded) for acceptance; returns in the req cycle.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_write = w; cmd_addr = a; cmd_data = d; cmd_valid = 1;
    for (int i = 0; i < 40 && !cmd_ready; i++) tick();
    chk("issue_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int be_cnt;
    int rq[8];
    int rc;
    #1 rst_n = 0;
    #11;
    chk("rst_st", 32'(st), 0);
    chk("rst_be_n", 32'(be_n), 1);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_addr", addr, 0);
    @(posedge clk); #3 rst_n = 1;
    idle(2);

    // Basic write: gnt at T+2, strb at T+5
    issue(1, 32'h1000, 32'hDEADBEEF);
    chk("bw_req_t1", 32'(req), 1);
    chk("bw_st_t1", 32'(st), 1);
    tick(); chk("bw_req_t2", 32'(req), 0); gnt = 1;
    tick(); gnt = 0;
    chk("bw_st_t3", 32'(st), 2);
    chk("bw_start_t3", 32'(start), 1);
    chk("bw_be_t3", 32'(be_n), 0);
    chk("bw_addr_t3", addr, 32'h1000);
    chk("bw_data_t3", data, 32'hDEADBEEF);
    tick(); chk("bw_st_t4", 32'(st), 3); chk("bw_start_t4", 32'(start), 0);
    tick(); chk("bw_st_t5", 32'(st), 3); chk("bw_addr_t5", addr, 32'h1000); strb = 1;
    tick(); strb = 0;
    chk("bw_st_t6", 32'(st), 0);
    chk("bw_end_t6", 32'(end_), 1);
    chk("bw_rsp_t6", 32'(rsp_valid), 1);
    chk("bw_stat_t6", 32'(rsp_status), 0);
    chk("bw_be_t6", 32'(be_n), 1);
    tick(); chk("bw_end_t7", 32'(end_), 0); chk("bw_addr_hold", addr, 32'h1000);

    // Zero-wait transfer
    issue(1, 32'h1004, 32'h0BADF00D);
    gnt = 1; tick(); gnt = 0; strb = 1;
    tick(); strb = 0;
    chk("zw_st", 32'(st), 0);
    chk("zw_end", 32'(end_), 1);
    chk("zw_stat", 32'(rsp_status), 0);

    // Priority: abort over fail over strb (read: data driven as 0)
    issue(0, 32'h2000, 32'h55555555);
    gnt = 1; tick(); gnt = 0;
    chk("rd_data0", data, 0);
    tick(); abort_n = 0; fail_n = 0; strb = 1;
    tick(); abort_n = 1; fail_n = 1; strb = 0;
    chk("pri_abort", 32'(rsp_status), 2);
    chk("pri_abort_end", 32'(end_), 1);
    issue(1, 32'h2004, 32'h12345678);
    gnt = 1; tick(); gnt = 0;
    tick(); fail_n = 0; strb = 1;
    tick(); fail_n = 1; strb = 0;
    chk("pri_fail", 32'(rsp_status), 1);

    // Timeout
    issue(1, 32'h3000, 32'hCAFEF00D);
    gnt = 1; tick(); gnt = 0;
    be_cnt = 0;
    for (int i = 0; i < 40 && !end_; i++) begin
      if (!be_n) be_cnt++;
      tick();
    end
    chk("tmo_end", 32'(end_), 1);
    chk("tmo_be_cycles", 32'(be_cnt), 16);
    chk("tmo_stat", 32'(rsp_status), 3);

    // Abort in ARB, then a late gnt
    issue(1, 32'h4000, 32'h1);
    idle(3); abort_n = 0;
    tick(); abort_n = 1;
    chk("arb_ab_rsp", 32'(rsp_valid), 1);
    chk("arb_ab_stat", 32'(rsp_status), 2);
    chk("arb_ab_end", 32'(end_), 0);
    chk("arb_ab_st", 32'(st), 0);
    gnt = 1; tick(); gnt = 0;
    chk("late_gnt_st", 32'(st), 0);
    chk("late_gnt_start", 32'(start), 0);

    // Rate limit: command and grant/strobe held high
    idle(12);
    chk("rate_rdy0", 32'(cmd_ready), 1);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h5000; cmd_data = 32'hA5A5A5A5;
    gnt = 1; strb = 1; rc = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (req) begin
        if (rc < 8) rq[rc] = i;
        rc++;
      end
      if (i == 6)  chk("rate_blk6", 32'(cmd_ready), 0);
      if (i == 10) chk("rate_blk10", 32'(cmd_ready), 0);
      if (i == 11) chk("rate_ok11", 32'(cmd_ready), 1);
    end
    cmd_valid = 0; gnt = 0; strb = 0;
    chk("rate_count", 32'(rc), 6);
    chk("rate_req0", 32'(rq[0]), 1);
    chk("rate_req1", 32'(rq[1]), 4);
    chk("rate_req2", 32'(rq[2]), 12);
    chk("rate_req3", 32'(rq[3]), 15);
    chk("rate_req4", 32'(rq[4]), 23);

    // Asynchronous reset mid-WAIT, then a fresh transfer
    idle(12);
    issue(1, 32'h6000, 32'h77777777);
    gnt = 1; tick(); gnt = 0;
    tick(); tick();
    chk("pre_rst_st", 32'(st), 3);
    #2 rst_n = 0;
    #1;
    chk("arst_be_n", 32'(be_n), 1);
    chk("arst_st", 32'(st), 0);
    chk("arst_req", 32'(req), 0);
    chk("arst_rsp", 32'(rsp_valid), 0);
    chk("arst_end", 32'(end_), 0);
    chk("arst_ready", 32'(cmd_ready), 0);
    @(posedge clk); #3 rst_n = 1;
    tick();
    chk("post_rst_ready", 32'(cmd_ready), 1);
    chk("post_rst_end", 32'(end_), 0);
    issue(1, 32'h7000, 32'h89ABCDEF);
    gnt = 1; tick(); gnt = 0;
    chk("post_rst_addr", addr, 32'h7000);
    strb = 1; tick(); strb = 0;
    chk("post_rst_rsp", 32'(rsp_valid), 1);
    chk("post_rst_stat", 32'(rsp_status), 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
